button_conditioner: RTL and testbench

Parametrised front-end that turns raw board switches and keys into clean game-control events for the game core.

---
 rtl/button_conditioner_pkg.sv | 17 +
 rtl/button_conditioner_if.sv | 23 ++
 rtl/button_conditioner_channel.sv | 121 ++++++++++++
 rtl/button_conditioner.sv | 64 ++++++
 tb/tb_button_conditioner.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and sizing helpers for the button conditioner slice.
package button_pkg;

    // Per-channel autorepeat controller states.
    typedef enum logic [1:0] {
        REP_IDLE  = 2'd0,
        REP_DELAY = 2'd1,
        REP_RUN   = 2'd2
    } rep_state_t;

    // Width of a tick down-counter able to hold max(delay, rate).
    function automatic int unsigned rep_cnt_width(input int unsigned delay,
                                                  input int unsigned rate);
        return $clog2(((delay > rate) ? delay : rate) + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Board-pin / game-core signal bundle for the button conditioner.
interface button_conditioner_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] raw_i;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;
    logic [N_CH-1:0] fire_o;
    logic            tick_o;

    // Pin/consumer side: supplies raw levels, observes events.
    modport master (
        output raw_i,
        input  level_o, press_o, release_o, fire_o, tick_o
    );

    // Conditioner side.
    modport slave (
        input  raw_i,
        output level_o, press_o, release_o, fire_o, tick_o
    );
endinterface

// File: rtl/button_conditioner_channel.sv
// One input channel: polarity fix, 2-FF sync, tick debounce, edge pulses
// and the hold-to-autorepeat fire controller.
module button_channel
    import button_pkg::*;
#(
    parameter logic        ACTIVE_LOW     = 1'b1,
    parameter logic        REPEAT_EN      = 1'b0,
    parameter int unsigned DEBOUNCE_TICKS = 10,
    parameter int unsigned REPEAT_DELAY   = 400,
    parameter int unsigned REPEAT_RATE    = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic fire_pulse
);
    localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_TICKS - 1);
    localparam int unsigned RW = rep_cnt_width(REPEAT_DELAY, REPEAT_RATE);
    localparam logic [RW-1:0] RD_LOAD = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RR_LOAD = RW'(REPEAT_RATE);
    localparam logic [RW-1:0] RP_ONE  = RW'(1);

    logic          sync_a;
    logic          sync_b;
    logic [DW-1:0] db_cnt;
    rep_state_t    state;
    rep_state_t    state_nx;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_nx;

    // Normalise polarity to 1 = pressed and bring into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw ^ ACTIVE_LOW;
            sync_b <= sync_a;
        end
    end

    // Debounce: count ticks of sustained disagreement, toggle level and emit an edge pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            if (sync_b == level) begin
                db_cnt <= '0;
            end else if (tick) begin
                if (db_cnt == DB_LAST) begin
                    db_cnt        <= '0;
                    level         <= ~level;
                    press_pulse   <= ~level;
                    release_pulse <= level;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end
        end
    end

    // Autorepeat state and tick down-counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= REP_IDLE;
            rep_cnt <= '0;
        end else begin
            state   <= state_nx;
            rep_cnt <= rep_cnt_nx;
        end
    end

    // Fire on press, then on each expiry while held; release wins over a coincident expiry.
    always_comb begin
        state_nx   = state;
        rep_cnt_nx = rep_cnt;
        fire_pulse = 1'b0;
        if (release_pulse) begin
            state_nx   = REP_IDLE;
            rep_cnt_nx = '0;
        end else begin
            case (state)
                REP_IDLE: begin
                    if (press_pulse) begin
                        fire_pulse = 1'b1;
                        if (REPEAT_EN) begin
                            state_nx   = REP_DELAY;
                            rep_cnt_nx = RD_LOAD;
                        end
                    end
                end
                REP_DELAY, REP_RUN: begin
                    if (tick) begin
                        if (rep_cnt == RP_ONE) begin
                            fire_pulse = 1'b1;
                            rep_cnt_nx = RR_LOAD;
                            state_nx   = REP_RUN;
                        end else begin
                            rep_cnt_nx = rep_cnt - 1'b1;
                        end
                    end
                end
                default: begin
                    state_nx   = REP_IDLE;
                    rep_cnt_nx = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Board switch/key front-end: shared tick prescaler plus N_CH independent channels.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned     N_CH            = 4,
    parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = '1,
    parameter logic [N_CH-1:0] REPEAT_MASK     = '0,
    parameter int unsigned     TICK_DIV        = 50000,
    parameter int unsigned     DEBOUNCE_TICKS  = 10,
    parameter int unsigned     REPEAT_DELAY    = 400,
    parameter int unsigned     REPEAT_RATE     = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    button_conditioner_if.slave   bus
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]   pre_cnt;
    logic            tick;
    logic [N_CH-1:0] level_v;
    logic [N_CH-1:0] press_v;
    logic [N_CH-1:0] release_v;
    logic [N_CH-1:0] fire_v;

    // Free-running 0..TICK_DIV-1 prescaler.
    always_ff @(posedge clk) begin
        if (reset || pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Gated by reset so TICK_DIV = 1 still reads 0 while reset is held.
    assign tick = (pre_cnt == PRE_LAST) && !reset;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW     (ACTIVE_LOW_MASK[i]),
            .REPEAT_EN      (REPEAT_MASK[i]),
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .tick          (tick),
            .raw           (bus.raw_i[i]),
            .level         (level_v[i]),
            .press_pulse   (press_v[i]),
            .release_pulse (release_v[i]),
            .fire_pulse    (fire_v[i])
        );
    end

    assign bus.level_o   = level_v;
    assign bus.press_o   = press_v;
    assign bus.release_o = release_v;
    assign bus.fire_o    = fire_v;
    assign bus.tick_o    = tick;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse events are queued
// with their exact cycle when stimulus is driven and matched by a monitor.
module tb_button_conditioner;
    localparam int unsigned TD = 4;
    localparam int unsigned DB = 3;
    localparam int unsigned RD = 5;
    localparam int unsigned RR = 2;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [3:0]  fire;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int unsigned cyc = 0;
    int unsigned ph = 0;
    int          checks = 0;
    int          failures = 0;
    ev_t         sb[$];

    button_conditioner_if #(.N_CH(4)) bus();

    button_conditioner #(
        .N_CH            (4),
        .ACTIVE_LOW_MASK (4'b1111),
        .REPEAT_MASK     (4'b0010),
        .TICK_DIV        (TD),
        .DEBOUNCE_TICKS  (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // First tick cycle at or after t, given ticks at ph, ph+TD, ...
    function automatic int unsigned next_tick(input int unsigned t);
        int unsigned u = t;
        while (u < ph || ((u - ph) % TD) != 0) u++;
        return u;
    endfunction

    // Cycle in which level_o shows a change of a raw pin driven in cycle c.
    function automatic int unsigned lvl_cycle(input int unsigned c);
        return next_tick(c + 2) + (DB - 1) * TD + 1;
    endfunction

    // Queue the events of one hold; with_rel = 0 means the hold is cut by reset at c+hold.
    task automatic plan_hold(input logic [3:0] m, input int unsigned c, input int unsigned hold,
                             input bit rep, input bit with_rel);
        int unsigned l;
        int unsigned lr;
        int unsigned f;
        l  = lvl_cycle(c);
        lr = with_rel ? lvl_cycle(c + hold) : c + hold;
        sb.push_back('{l, m, 4'b0000, m});
        if (rep) begin
            f = next_tick(l + 1) + (RD - 1) * TD;
            while (f < lr) begin
                sb.push_back('{f, 4'b0000, 4'b0000, m});
                f += RR * TD;
            end
        end
        if (with_rel) sb.push_back('{lr, 4'b0000, m, 4'b0000});
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {bus.level_o, bus.press_o, bus.release_o, bus.fire_o, bus.tick_o}, '0);
    endtask

    task automatic monitor();
        logic [3:0]  exp_lvl = '0;
        logic        prev_rst = 1'b1;
        logic [11:0] pulses;
        ev_t         e;
        forever begin
            @(negedge clk);
            if (prev_rst && reset) exp_lvl = '0;
            prev_rst = reset;
            if (cyc < 2) continue;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                check_eq("ev_missing_at", cyc, e.cyc);
            end
            pulses = {bus.press_o, bus.release_o, bus.fire_o};
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check_eq("ev_press", bus.press_o, e.press);
                check_eq("ev_release", bus.release_o, e.rel);
                check_eq("ev_fire", bus.fire_o, e.fire);
                exp_lvl = (exp_lvl | e.press) & ~e.rel;
            end else if (pulses != '0) begin
                check_eq("ev_unexpected", pulses, '0);
            end
            check_eq("level", bus.level_o, exp_lvl);
        end
    endtask

    initial begin
        int unsigned c;
        int unsigned x;
        bus.raw_i = 4'hF;
        reset = 1'b1;
        fork
            monitor();
        join_none

        // 1: reset holds outputs low; tick phase after release
        step(2);
        repeat (8) begin
            check_all_zero("rst_outputs");
            step(1);
        end
        reset = 1'b0;
        ph = cyc + 3;
        for (int k = 0; k < 16; k++) begin
            check_eq("tick_phase", bus.tick_o, (k >= 3 && ((k - 3) % 4) == 0));
            step(1);
        end

        // 2: short bounce ignored, then a real press on channel 0
        step(3);
        bus.raw_i[0] = 1'b0;
        step(6);
        bus.raw_i[0] = 1'b1;
        step(12);
        c = cyc;
        bus.raw_i[0] = 1'b0;
        plan_hold(4'b0001, c, 30, 1'b0, 1'b1);
        step(30);
        bus.raw_i[0] = 1'b1;
        step(25);

        // 3: autorepeat channel 1 held 40 ticks
        c = cyc;
        bus.raw_i[1] = 1'b0;
        plan_hold(4'b0010, c, 160, 1'b1, 1'b1);
        step(160);
        bus.raw_i[1] = 1'b1;
        step(25);

        // 4: non-repeat channel 2 held 30 ticks
        c = cyc;
        bus.raw_i[2] = 1'b0;
        plan_hold(4'b0100, c, 120, 1'b0, 1'b1);
        step(120);
        bus.raw_i[2] = 1'b1;
        step(25);

        // 5: channels 0 and 3 together
        c = cyc;
        bus.raw_i = 4'b0110;
        plan_hold(4'b1001, c, 30, 1'b0, 1'b1);
        step(30);
        bus.raw_i = 4'hF;
        step(25);

        // 6: reset while channel 1 is repeating and still held
        c = cyc;
        bus.raw_i[1] = 1'b0;
        x = lvl_cycle(c) + 30;
        plan_hold(4'b0010, c, x - c, 1'b1, 1'b0);
        step(x - cyc);
        reset = 1'b1;
        repeat (3) begin
            step(1);
            check_all_zero("rst_mid_outputs");
        end
        reset = 1'b0;
        ph = cyc + 3;
        c = cyc;
        plan_hold(4'b0010, c, 60, 1'b1, 1'b1);
        step(60);
        bus.raw_i[1] = 1'b1;
        step(30);

        check_eq("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
